// File: rtl/instr_loader.sv
// Boot-time instruction loader: assembles big-endian 32-bit words from a byte stream,
// writes them to instruction memory and holds the CPU in reset until the load completes.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_rst_no,
  output logic              busy_o,
  output logic              err_o
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   ptr_inc;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              byte_ready;
  logic              start_ok;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign ptr_inc = ptr_q + ONE_L;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    byte_ready = 1'b0;
    start_ok   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE, S_RUN, S_ERR: start_ok = start_i;
      S_RECV: begin
        byte_ready = 1'b1;
        if (byte_valid_i) begin
          shift_d = {shift_q[15:0], byte_data_i};
          bcnt_d  = bcnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byte_data_i;
`endif
          // Fourth byte: the full word goes straight to the write-port registers.
          if (bcnt_q == 2'd3) begin
            state_d    = S_WRITE;
            im_we_d    = 1'b1;
            im_addr_d  = ptr_q[ADDR_W-1:0];
            im_wdata_d = {shift_q, byte_data_i};
          end
        end
      end
      S_WRITE: begin
        ptr_d = ptr_inc;
        if (ptr_inc == cnt_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_RUN;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid_i) state_d = (byte_data_i == csum_q) ? S_RUN : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A start is honoured only outside an active load.
    if (start_ok) begin
      cnt_d  = word_count_i;
      ptr_d  = '0;
      bcnt_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_d = '0;
`endif
      if (word_count_i == '0)          state_d = S_RUN;
      else if (word_count_i > DEPTH_L) state_d = S_ERR;
      else                             state_d = S_RECV;
    end
  end

  // Registered status outputs follow the state being entered.
  always_comb begin
    cpu_rst_n_d = (state_d == S_RUN);
    err_d       = (state_d == S_ERR);
    busy_d      = (state_d == S_RECV) || (state_d == S_WRITE)
`ifdef INSTR_LOADER_CHECKSUM_EN
                  || (state_d == S_CHECK)
`endif
                  ;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign byte_ready_o = byte_ready;
  assign im_we_o      = im_we_q;
  assign im_addr_o    = im_addr_q;
  assign im_wdata_o   = im_wdata_q;
  assign cpu_rst_no   = cpu_rst_n_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random byte streams checked against a
// word-list model built from the payload bytes (big-endian, sequential addresses).
`timescale 1ns/1ps
module tb_instr_loader;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W:0]   word_count_i = '0;
  logic              byte_valid_i = 1'b0;
  logic [7:0]        byte_data_i = '0;
  logic              byte_ready_o, im_we_o, cpu_rst_no, busy_o, err_o;
  logic [ADDR_W-1:0] im_addr_o;
  logic [31:0]       im_wdata_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic cpu_prev = 1'b0;
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_b[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          rise_q[$];

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .word_count_i(word_count_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .im_we_o(im_we_o), .im_addr_o(im_addr_o), .im_wdata_o(im_wdata_o),
    .cpu_rst_no(cpu_rst_no), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Write-port and CPU-release monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (im_we_o) begin
      wr_addr.push_back(int'(im_addr_o));
      wr_data.push_back(im_wdata_o);
      wr_cyc.push_back(cyc);
    end
    if (cpu_rst_no && !cpu_prev) rise_q.push_back(cyc);
    cpu_prev <= cpu_rst_no;
  end

  // Reference model: word i is bytes 4i..4i+3, first byte most significant.
  function automatic logic [31:0] exp_word(input int i);
    return {exp_b[4*i], exp_b[4*i+1], exp_b[4*i+2], exp_b[4*i+3]};
  endfunction

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (exp_b[i]) x ^= exp_b[i];
    return x;
  endfunction

  task automatic load_tx();
    tx_q = exp_b;
`ifdef INSTR_LOADER_CHECKSUM_EN
    tx_q.push_back(xor_all());
`endif
  endtask

  task automatic build(input int n);
    exp_b.delete();
    for (int i = 0; i < 4*n; i++) exp_b.push_back(8'($urandom_range(1, 255)));
    load_tx();
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); rise_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_i);
      start_i = 1'b0;
      byte_valid_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_log();
  endtask

  task automatic do_start(input int n, output int c0);
    @(negedge clk_i);
    start_i = 1'b1;
    byte_valid_i = 1'b0;
    word_count_i = (ADDR_W+1)'(n);
    c0 = cyc;
    clear_log();
  endtask

  // mode 0: valid held, 1: valid toggles, 2: random gaps. poke: stray start pulses.
  task automatic feed(input int mode, input bit poke);
    int guard = 0;
    while (tx_q.size() != 0 && guard < 4000) begin
      @(negedge clk_i);
      guard++;
      case (mode)
        0:       byte_valid_i = 1'b1;
        1:       byte_valid_i = guard[0];
        default: byte_valid_i = ($urandom_range(99) >= 30);
      endcase
      byte_data_i  = byte_valid_i ? tx_q[0] : 8'($urandom);
      start_i      = poke && ($urandom_range(5) == 0);
      word_count_i = (ADDR_W+1)'($urandom_range(0, DEPTH + 1));
      if (byte_valid_i && byte_ready_o) void'(tx_q.pop_front());
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL feed_timeout: %0d bytes left, want 0", tx_q.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", byte_ready_o); end
    checks++; if (im_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", im_we_o); end
    checks++; if (im_addr_o !== '0) begin errors++; $display("FAIL rst_addr: got %0h want 0", im_addr_o); end
    checks++; if (im_wdata_o !== '0) begin errors++; $display("FAIL rst_wdata: got %0h want 0", im_wdata_o); end
    checks++; if (cpu_rst_no !== 1'b0) begin errors++; $display("FAIL rst_cpu: got %b want 0", cpu_rst_no); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
    rst_i = 1'b1;
    tick(2);
    checks++; if (cpu_rst_no !== 1'b0 || byte_ready_o !== 1'b0) begin
      errors++; $display("FAIL idle_hold: cpu=%b ready=%b want 0 0", cpu_rst_no, byte_ready_o);
    end
  endtask

  task automatic test_two_words();
    int c0, rel;
    do_reset();
    exp_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    load_tx();
    do_start(2, c0);
    feed(0, 1'b0);
    tick(3);
`ifdef INSTR_LOADER_CHECKSUM_EN
    rel = 12;
`else
    rel = 11;
`endif
    checks++; if (wr_data.size() != 2) begin errors++; $display("FAIL two_count: got %0d want 2", wr_data.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wr_data.size() || wr_data[i] !== exp_word(i) || wr_addr[i] != i || wr_cyc[i] - c0 != 5*(i+1)) begin
        errors++;
        $display("FAIL two_word%0d: got %0h@%0d cyc %0d want %0h@%0d cyc %0d", i,
                 (i < wr_data.size()) ? wr_data[i] : 32'hx, (i < wr_addr.size()) ? wr_addr[i] : -1,
                 (i < wr_cyc.size()) ? wr_cyc[i] - c0 : -1, exp_word(i), i, 5*(i+1));
      end
    end
    checks++; if (rise_q.size() != 1 || rise_q[0] - c0 != rel) begin
      errors++; $display("FAIL two_release: got cyc %0d want %0d", (rise_q.size() != 0) ? rise_q[0] - c0 : -1, rel);
    end
  endtask

  task automatic test_zero_count();
    int c0;
    do_reset();
    do_start(0, c0);
    tick(1);
    checks++; if (cpu_rst_no !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL zero_run: cpu/err/busy got %b%b%b want 100", cpu_rst_no, err_o, busy_o);
    end
    tick(3);
    checks++; if (wr_data.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_data.size()); end
  endtask

  task automatic test_gappy();
    int c0;
    do_reset();
    build(1);
    do_start(1, c0);
    feed(1, 1'b0);
    tick(2);
    checks++; if (wr_data.size() != 1 || wr_data[0] !== exp_word(0) || wr_addr[0] != 0) begin
      errors++; $display("FAIL gappy_word: got %0d writes first %0h want 1 write %0h",
                         wr_data.size(), (wr_data.size() != 0) ? wr_data[0] : 32'hx, exp_word(0));
    end
    checks++; if (cpu_rst_no !== 1'b1) begin errors++; $display("FAIL gappy_release: got %b want 1", cpu_rst_no); end
  endtask

  task automatic test_overflow();
    int c0;
    do_reset();
    do_start(DEPTH + 1, c0);
    tick(1);
    checks++; if (err_o !== 1'b1 || cpu_rst_no !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL ovf_err: err/cpu/busy got %b%b%b want 100", err_o, cpu_rst_no, busy_o);
    end
    repeat (4) begin
      @(negedge clk_i);
      byte_valid_i = 1'b1;
      byte_data_i = 8'($urandom);
      checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", byte_ready_o); end
    end
    tick(2);
    checks++; if (wr_data.size() != 0 || err_o !== 1'b1 || cpu_rst_no !== 1'b0) begin
      errors++; $display("FAIL ovf_hold: writes=%0d err=%b cpu=%b want 0 1 0", wr_data.size(), err_o, cpu_rst_no);
    end
    build(1);
    do_start(1, c0);
    tick(1);
    checks++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL ovf_clear: err/busy got %b%b want 01", err_o, busy_o);
    end
    feed(0, 1'b0);
    tick(2);
    checks++; if (wr_data.size() != 1 || wr_data[0] !== exp_word(0) || cpu_rst_no !== 1'b1) begin
      errors++; $display("FAIL ovf_reload: writes=%0d cpu=%b want 1 write %0h cpu 1", wr_data.size(), cpu_rst_no, exp_word(0));
    end
  endtask

  task automatic test_full_depth();
    int c0, bad;
    do_reset();
    build(DEPTH);
    do_start(DEPTH, c0);
    feed(2, 1'b1);
    tick(3);
    checks++; if (wr_data.size() != DEPTH) begin errors++; $display("FAIL full_count: got %0d want %0d", wr_data.size(), DEPTH); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (i >= wr_data.size() || wr_data[i] !== exp_word(i) || wr_addr[i] != i) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL full_word%0d: got %0h want %0h", i, (i < wr_data.size()) ? wr_data[i] : 32'hx, exp_word(i));
      end
    end
    checks++; if (cpu_rst_no !== 1'b1 || err_o !== 1'b0) begin
      errors++; $display("FAIL full_release: cpu/err got %b%b want 10", cpu_rst_no, err_o);
    end
  endtask

  task automatic test_reset_midload();
    int c0;
    do_reset();
    build(1);
    do_start(1, c0);
    feed(0, 1'b0);
    tick(2);
    build(2);
    while (tx_q.size() > 2) void'(tx_q.pop_back());
    do_start(2, c0);
    feed(0, 1'b0);
    #2 rst_i = 1'b0;
    #1;
    checks++; if ({byte_ready_o, im_we_o, cpu_rst_no, busy_o, err_o} !== 5'b0 || im_addr_o !== '0 || im_wdata_o !== '0) begin
      errors++; $display("FAIL midrst_outputs: ready/we/cpu/busy/err=%b addr=%0h wdata=%0h want all 0",
                         {byte_ready_o, im_we_o, cpu_rst_no, busy_o, err_o}, im_addr_o, im_wdata_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    build(1);
    do_start(1, c0);
    feed(0, 1'b0);
    tick(2);
    checks++; if (wr_data.size() != 1 || wr_data[0] !== exp_word(0) || wr_addr[0] != 0) begin
      errors++; $display("FAIL midrst_reload: got %0d writes first %0h want 1 write %0h",
                         wr_data.size(), (wr_data.size() != 0) ? wr_data[0] : 32'hx, exp_word(0));
    end
  endtask

  task automatic test_back_to_back();
    int c0, n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      build(n);
      do_start(n, c0);
      tick(1);
      checks++; if (cpu_rst_no !== 1'b0 || busy_o !== 1'b1) begin
        errors++; $display("FAIL b2b_drop%0d: cpu/busy got %b%b want 01", r, cpu_rst_no, busy_o);
      end
      feed(2, 1'b1);
      tick(3);
      checks++; if (wr_data.size() != n) begin errors++; $display("FAIL b2b_count%0d: got %0d want %0d", r, wr_data.size(), n); end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (i >= wr_data.size() || wr_data[i] !== exp_word(i) || wr_addr[i] != i) begin
          errors++; $display("FAIL b2b_word%0d_%0d: got %0h want %0h", r, i, (i < wr_data.size()) ? wr_data[i] : 32'hx, exp_word(i));
        end
      end
      checks++; if (cpu_rst_no !== 1'b1) begin errors++; $display("FAIL b2b_release%0d: got %b want 1", r, cpu_rst_no); end
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int c0;
    do_reset();
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_q = exp_b;
    tx_q.push_back(8'h44);
    do_start(1, c0);
    feed(0, 1'b0);
    tick(2);
    checks++; if (wr_data.size() != 1 || wr_data[0] !== 32'h11223344) begin
      errors++; $display("FAIL csum_word: got %0d writes want 1 of 11223344", wr_data.size());
    end
    checks++; if (cpu_rst_no !== 1'b1 || err_o !== 1'b0) begin
      errors++; $display("FAIL csum_good: cpu/err got %b%b want 10", cpu_rst_no, err_o);
    end
    tx_q = exp_b;
    tx_q.push_back(8'h45);
    do_start(1, c0);
    feed(0, 1'b0);
    tick(2);
    checks++; if (err_o !== 1'b1 || cpu_rst_no !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL csum_bad: err/cpu/busy got %b%b%b want 100", err_o, cpu_rst_no, busy_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_gappy();
    test_overflow();
    test_full_depth();
    test_reset_midload();
    test_back_to_back();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
